// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand is split into GROUP-bit lookahead groups. Each pipeline stage
// resolves one group using the carry registered by the previous stage. The
// not-yet-used operand bits travel forward with the beat, and so do the
// already-computed low sum bits. As a result, all sum bits of a beat leave
// the last stage together.
// The pipeline enable depends only on the output handshake, so the whole
// pipeline advances or holds as one unit. Bubbles are kept as they are.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NG  = WIDTH / GROUP;
    // Operand skew registers feed only stages 1..NG-1.
    localparam int NOP = (NG > 1) ? NG - 1 : 1;

    // Per-stage pipeline registers
    logic             valid_reg [NG];
    logic [WIDTH-1:0] sum_reg   [NG];
    logic             carry_reg [NG];
    logic [WIDTH-1:0] a_reg     [NOP];
    logic [WIDTH-1:0] b_reg     [NOP];
    logic             ovf_reg;

    // Per-stage inputs: from the ports for stage 0, else from the previous stage
    logic [WIDTH-1:0] stg_a [NG];
    logic [WIDTH-1:0] stg_b [NG];
    logic [WIDTH-1:0] stg_s [NG];
    logic             stg_c [NG];
    logic             stg_v [NG];

    // Per-stage combinational results
    logic [WIDTH-1:0] sum_next       [NG];
    logic             carry_next     [NG];
    logic             msb_carry_next [NG];

    logic en;

    // One lookahead group.
    // Every carry is written as a flat sum of products of the group's
    // generate and propagate terms and the group carry-in, not as a ripple.
    // Result layout: {carry into MSB, group carry-out, sum bits}.
    function automatic logic [GROUP+1:0] cla_group(
        input logic [GROUP-1:0] ga,
        input logic [GROUP-1:0] gb,
        input logic             gc
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        g    = ga & gb;
        p    = ga ^ gb;
        c    = '0;
        c[0] = gc;
        for (int i = 0; i < GROUP; i++) begin
            // Incoming carry propagated through bits 0..i
            term = gc;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = term;
            // Carry generated at bit j and propagated through bits j+1..i
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    // The whole pipeline stalls only when a finished result is not taken.
    assign en        = !(out_valid && !out_ready);
    assign in_ready  = en;
    assign out_valid = valid_reg[NG-1];
    assign s         = sum_reg[NG-1];
    assign cout      = carry_reg[NG-1];
    assign ovf       = ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_stage
            logic [GROUP+1:0] grp;
            logic [WIDTH-1:0] merged;

            if (gi == 0) begin : g_in
                // Subtraction is A + ~B + 1, so B is inverted and cin is forced to 1.
                assign stg_a[gi] = a;
                assign stg_b[gi] = sub ? ~b : b;
                assign stg_c[gi] = sub ? 1'b1 : cin;
                assign stg_v[gi] = in_valid;
                assign stg_s[gi] = '0;
            end else begin : g_fwd
                assign stg_a[gi] = a_reg[gi-1];
                assign stg_b[gi] = b_reg[gi-1];
                assign stg_c[gi] = carry_reg[gi-1];
                assign stg_v[gi] = valid_reg[gi-1];
                assign stg_s[gi] = sum_reg[gi-1];
            end

            assign grp = cla_group(stg_a[gi][GROUP*gi +: GROUP],
                                   stg_b[gi][GROUP*gi +: GROUP],
                                   stg_c[gi]);

            // Put this group's sum bits into the partial sum carried forward
            always_comb begin
                merged                     = stg_s[gi];
                merged[GROUP*gi +: GROUP]  = grp[GROUP-1:0];
            end

            assign sum_next[gi]       = merged;
            assign carry_next[gi]     = grp[GROUP];
            assign msb_carry_next[gi] = grp[GROUP+1];
        end
    endgenerate

    // Advance every stage together when enabled. Reset clears all state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NG; k++) begin
                valid_reg[k] <= 1'b0;
                sum_reg[k]   <= '0;
                carry_reg[k] <= 1'b0;
            end
            for (int k = 0; k < NOP; k++) begin
                a_reg[k] <= '0;
                b_reg[k] <= '0;
            end
            ovf_reg <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < NG; k++) begin
                valid_reg[k] <= stg_v[k];
                sum_reg[k]   <= sum_next[k];
                carry_reg[k] <= carry_next[k];
            end
            for (int k = 0; k < NG - 1; k++) begin
                a_reg[k] <= stg_a[k];
                b_reg[k] <= stg_b[k];
            end
            // Signed overflow: carry into the MSB differs from carry out of it
            ovf_reg <= msb_carry_next[NG-1] ^ carry_next[NG-1];
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the team's 4-bit combinational CLA. The WIDTH-bit operand is split into GROUP-bit lookahead groups, and the carry between groups is resolved in one pipeline stage per group. It uses valid/ready handshakes on input and output, sustains full throughput (one operation per cycle) and stalls under backpressure. It serves as the datapath arithmetic unit wherever a wide add at high clock rate is needed.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of GROUP and at least GROUP.
GROUP, 4, bits per carry-lookahead group; NG = WIDTH/GROUP pipeline stages.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  operand beat present.
in_ready  output  1  block can accept a beat this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in; ignored when sub=1.
sub  input  1  0: S = A + B + cin; 1: S = A - B, computed as A + ~B + 1.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts the result.
s  output  WIDTH  sum or difference.
cout  output  1  carry out of the MSB (for sub, 1 means no borrow).
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all stage valid bits clear, so out_valid=0;
  - s=0, cout=0, ovf=0;
  - in_ready=1 in the first cycle after reset.
- A reset mid-operation discards every in-flight beat; none appears at the output.
- Pipeline enable: en = !(out_valid && !out_ready).
  - in_ready = en, a combinational function of out_valid and out_ready only.
  - When en=0, every stage holds its data and valid bit.
- Accept: in_valid && in_ready at an edge. B is inverted when sub=1, and carry-in = sub ? 1 : cin.
- Stage k (k = 0..NG-1):
  - computes group k with 4-style generate/propagate lookahead, using the carry registered from stage k-1 (stage 0 uses the effective cin);
  - registers sum bits [GROUP*k +: GROUP] and the group carry-out;
  - forwards the higher, still-unused operand bits and the lower, already-computed sum bits (skew/deskew registers), so the sum bits of one beat emerge aligned.
- Latency: exactly NG cycles from accept to out_valid with no stall. A beat accepted at edge t is visible on s/cout/ovf after edge t+NG-1 and completes on the first edge ≥ t+NG-1 where out_ready=1.
- Throughput: one beat per cycle while out_ready=1. Beat order is preserved.
- Bubbles: a stage whose valid bit is 0 still advances when en=1. Bubbles are not collapsed; the only stall condition is en=0.
- Output hold: while out_valid=1 and out_ready=0, s/cout/ovf stay stable.
- Both in the same cycle: a final-stage beat that transfers (out_ready=1) allows a new input to be accepted in that cycle.
- Wrap-around: the sum is modulo 2^WIDTH; the carry appears only on cout.
- ovf is computed in the final stage from the MSB group's internal carry into the MSB and its carry-out.
- WIDTH=GROUP gives a single-stage registered CLA with latency 1.
- X on a/b/cin/sub while in_valid=0 must not propagate to out_valid.

Test Plan:
- Reset, then add 0x0001 + 0x0000, cin=0 -> after 4 cycles out_valid=1, s=0x0001, cout=0, ovf=0. During reset out_valid=0 and s=0.
- Back-to-back stream (WIDTH=16) with out_ready=1:
  - 0xFFFF + 0x0001, cin=0 -> s=0x0000, cout=1, ovf=0;
  - 0x7FFF + 0x0001 -> s=0x8000, cout=0, ovf=1;
  - 0x1234 + 0x4321, cin=1 -> s=0x5556.
  - Required: results appear on 3 consecutive cycles starting 4 cycles after the first accept.
- Subtract: sub=1, a=0x0005, b=0x0003 (cin=1, ignored) -> s=0x0002, cout=1. Then a=0x0003, b=0x0005 -> s=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> s=0x7FFF, ovf=1.
- Backpressure: stream 6 beats, hold out_ready=0 for 5 cycles once the first result arrives.
  - While held: in_ready=0, s stable, no beat lost or duplicated.
  - After release: all 6 results in order.
- Mid-operation reset: accept 3 beats, assert rst for 1 cycle before any result -> out_valid stays 0 and no stale beat appears. The next input returns its correct result after 4 cycles.
- Legacy config WIDTH=4, GROUP=4:
  - a=4'hb, b=4'h6, cin=0 -> {cout,s}=17 after 1 cycle;
  - a=2, b=4, cin=1 -> 7;
  - a=5, b=3, cin=1 -> 9.
